// File: rtl/io_pkg.sv
// Shared constants and state encoding for the CPU-to-UART output stage.
package io_pkg;

    localparam logic [2:0] IO_CHAR_OFF = 3'h0;
    localparam logic [2:0] IO_HALT_OFF = 3'h4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } io_state_e;

endpackage

// File: rtl/io_fifo.sv
// Synchronous show-ahead byte FIFO; the head entry is always visible on rdata.
module io_fifo #(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [7:0]       wdata,
    input  logic             pop,
    output logic [7:0]       rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign count     = count_r;
    // Masked when empty so the head reads as zero straight out of reset.
    assign rdata     = empty ? 8'h00 : mem_r[rd_ptr_r];

    // Storage write; contents need no reset since empty masks the head.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/io_tx_buffer.sv
// CPU I/O window to UART transmitter: buffers char-out bytes and raises halt once drained.
module io_tx_buffer
    import io_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             io_we,
    input  logic [2:0]       io_addr,
    input  logic [7:0]       io_wdata,
    output logic             io_full,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [CNT_W-1:0] count,
    output logic             halt
);

    io_state_e state_r;
    io_state_e state_next_s;
    logic      is_char_s;
    logic      is_halt_s;
    logic      push_s;
    logic      pop_s;
    logic      fifo_full_s;
    logic      fifo_empty_s;

    assign is_char_s = io_we && (io_addr == IO_CHAR_OFF);
    assign is_halt_s = io_we && (io_addr == IO_HALT_OFF);
    assign push_s    = is_char_s && (state_r == RUN);
    assign pop_s     = tx_valid && tx_ready;
    assign tx_valid  = !fifo_empty_s;
    assign io_full   = (state_r == RUN) && fifo_full_s;
    assign halt      = (state_r == HALTED);

    io_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .wdata (io_wdata),
        .pop   (pop_s),
        .rdata (tx_data),
        .count (count),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Run-state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // In DRAIN no push can occur and a pop needs data, so count==0 means nothing pending.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            RUN: begin
                if (is_halt_s) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = RUN;
                end
            end
            DRAIN: begin
                if (fifo_empty_s) begin
                    state_next_s = HALTED;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            HALTED:  state_next_s = HALTED;
            default: state_next_s = RUN;
        endcase
    end

endmodule
